// File: rtl/j1_uart.sv
// J1 memory-mapped UART: DATA at 0xF000, STATUS at 0xF002, 8N1 framing, TX FIFO.
// Define J1_UART_LOOPBACK_EN to feed the TX serial stream into RX internally and hold uart_txd high.
//
// state   | meaning (TX and RX FSMs share the encoding)
// IDLE    | line idle, waiting for a byte (TX) or a falling edge (RX)
// START   | start bit (RX: half-bit wait, then glitch check)
// DATA    | eight data bits, LSB first
// STOP    | stop bit
module j1_uart #(
    parameter int CLK_DIV  = 434,
    parameter int TX_DEPTH = 4
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_n_i,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_dout,
    output logic [15:0] io_din,
    output logic        uart_txd,
    input  logic        uart_rxd
);
    localparam logic [15:0] ADDR_DATA = 16'hF000;
    localparam logic [15:0] ADDR_STAT = 16'hF002;
    localparam logic [15:0] DIV_M1    = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_M1   = 16'((CLK_DIV / 2) - 1);
    localparam int          AW        = $clog2(TX_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    logic data_sel, stat_sel, data_rd, data_wr, ovr_clr;
    assign data_sel = (io_addr == ADDR_DATA);
    assign stat_sel = (io_addr == ADDR_STAT);
    assign data_rd  = io_rd & data_sel;
    assign data_wr  = io_wr & data_sel;
    assign ovr_clr  = io_wr & stat_sel & io_dout[3];

    logic unused_dout_bits;
    assign unused_dout_bits = &{1'b0, io_dout[15:8]};

    // ---------------- TX FIFO ----------------
    logic [7:0]  fifo_mem [TX_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        fifo_empty, fifo_full, push, pop;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push       = data_wr & ~fifo_full;

    always_ff @(posedge sys_clk_i) begin
        if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= io_dout[7:0];
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // ---------------- TX FSM ----------------
    state_e      tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        tx_line;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        pop        = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    tx_sh_d    = fifo_mem[rd_ptr_q[AW-1:0]];
                    tx_cnt_d   = DIV_M1;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d   = DIV_M1;
                    tx_bit_d   = 3'd0;
                    tx_state_d = S_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d = DIV_M1;
                    tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                    if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
                    else                  tx_bit_d   = tx_bit_q + 3'd1;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (tx_cnt_q == 16'd0) begin
                    // Chain straight into the next start bit when more data is queued.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        tx_sh_d    = fifo_mem[rd_ptr_q[AW-1:0]];
                        tx_cnt_d   = DIV_M1;
                        tx_state_d = S_START;
                    end else begin
                        tx_state_d = S_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_line = 1'b1;
        if (tx_state_q == S_START)     tx_line = 1'b0;
        else if (tx_state_q == S_DATA) tx_line = tx_sh_q[0];
    end

    // ---------------- RX path ----------------
    logic rx_in;

`ifdef J1_UART_LOOPBACK_EN
    assign rx_in    = tx_line;
    assign uart_txd = 1'b1;
`else
    assign rx_in    = uart_rxd;
    assign uart_txd = tx_line;
`endif

    logic [1:0]  rx_sync_q;
    logic        rx_prev_q, rx_s;
    state_e      rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d, rx_done;

    assign rx_s = rx_sync_q[1];

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_done    = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    rx_cnt_d   = HALF_M1;
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                if (rx_cnt_q == 16'd0) begin
                    if (rx_s) begin
                        rx_state_d = S_IDLE;
                    end else begin
                        rx_cnt_d   = DIV_M1;
                        rx_bit_d   = 3'd0;
                        rx_state_d = S_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_cnt_d = DIV_M1;
                    rx_sh_d  = {rx_s, rx_sh_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_done    = rx_s;
                    rx_state_d = S_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // A completion that coincides with a DATA read keeps valid set and is not an overrun.
    always_comb begin
        rx_data_d  = rx_done ? rx_sh_q : rx_data_q;
        rx_valid_d = rx_done ? 1'b1 : (data_rd ? 1'b0 : rx_valid_q);
        rx_ovr_d   = rx_ovr_q;
        if (ovr_clr) rx_ovr_d = 1'b0;
        if (rx_done && rx_valid_q && !data_rd) rx_ovr_d = 1'b1;
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 3'd0;
            tx_sh_q    <= 8'h00;
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_sh_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            rx_sync_q  <= {rx_sync_q[0], rx_in};
            rx_prev_q  <= rx_s;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
        end
    end

    always_comb begin
        io_din = 16'h0000;
        if (data_sel)
            io_din = {8'h00, rx_data_q};
        else if (stat_sel)
            io_din = {12'h000, rx_ovr_q, fifo_empty & (tx_state_q == S_IDLE), fifo_full, rx_valid_q};
    end
endmodule

// File: tb/tb_j1_uart.sv
// Directed and randomized bench for j1_uart (CLK_DIV=8, TX_DEPTH=4) with a serial line monitor
// and a byte-level receive model.
module tb_j1_uart;
    localparam int CLK_DIV  = 8;
    localparam int TX_DEPTH = 4;
    localparam logic [15:0] A_DATA = 16'hF000;
    localparam logic [15:0] A_STAT = 16'hF002;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        io_rd = 1'b0;
    logic        io_wr = 1'b0;
    logic [15:0] io_addr = 16'h0000;
    logic [15:0] io_dout = 16'h0000;
    logic [15:0] io_din;
    logic        uart_txd;
    logic        uart_rxd = 1'b1;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    logic [7:0] mon_q[$];
    int         mon_t[$];
    logic [7:0] mon_b;
    int         mon_start;

    j1_uart #(.CLK_DIV(CLK_DIV), .TX_DEPTH(TX_DEPTH)) dut (
        .sys_clk_i  (clk),
        .sys_rst_n_i(rst_n),
        .io_rd      (io_rd),
        .io_wr      (io_wr),
        .io_addr    (io_addr),
        .io_dout    (io_dout),
        .io_din     (io_din),
        .uart_txd   (uart_txd),
        .uart_rxd   (uart_rxd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Decodes frames on uart_txd at bit centres; records the cycle each start bit began.
    initial begin
        forever begin
            @(negedge uart_txd);
            mon_start = cyc;
            repeat (CLK_DIV / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CLK_DIV) @(negedge clk);
                mon_b[i] = uart_txd;
            end
            repeat (CLK_DIV) @(negedge clk);
            mon_q.push_back(mon_b);
            mon_t.push_back(mon_start);
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data);
        io_addr = addr;
        io_dout = data;
        io_wr   = 1'b1;
        @(negedge clk);
        io_wr   = 1'b0;
    endtask

    task automatic rd(input logic [15:0] addr, output logic [15:0] data);
        io_addr = addr;
        io_rd   = 1'b1;
        #1 data = io_din;
        @(negedge clk);
        io_rd   = 1'b0;
    endtask

    task automatic peek(input logic [15:0] addr, output logic [15:0] data);
        io_addr = addr;
        #1 data = io_din;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        uart_rxd = 1'b0;
        idle(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            idle(CLK_DIV);
        end
        uart_rxd = stop_bit;
        idle(CLK_DIV);
        uart_rxd = 1'b1;
        idle(4);
    endtask

    task automatic wait_mon(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (mon_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 16'(mon_q.size()), 16'(n));
    endtask

    logic [15:0] d;
    logic        samp [90];
    logic [9:0]  frame_bits;
    logic [7:0]  exp_q[$];
    int          first_zero, ok_cnt, nb;
    logic [7:0]  rb;
    logic        m_valid, m_ovr;
    logic [7:0]  m_data;

    initial begin
        // ---- reset values ----
        idle(3);
        check("rst_txd", 16'(uart_txd), 16'h0001);
        peek(A_STAT, d); check("rst_status_during", d, 16'h0004);
        peek(A_DATA, d); check("rst_data_during", d, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        rd(A_STAT, d); check("rst_status_after", d, 16'h0004);
        rd(16'hF004, d); check("other_addr_read", d, 16'h0000);
        wr(16'hF004, 16'h00AA);
        idle(3);
        peek(A_STAT, d); check("other_addr_write_ignored", d, 16'h0004);
        check("other_addr_no_tx", 16'(mon_q.size()), 16'h0000);
        @(negedge clk);

        // ---- single byte 0x55, exact bit timing ----
        frame_bits = {1'b1, 8'h55, 1'b0};
        wr(A_DATA, 16'h0055);
        for (int k = 0; k < 90; k++) begin
            samp[k] = uart_txd;
            @(negedge clk);
        end
        first_zero = -1;
        for (int k = 0; k < 90; k++)
            if (first_zero < 0 && samp[k] == 1'b0) first_zero = k;
        check("tx55_start_latency", 16'(first_zero), 16'd1);
        for (int j = 0; j < 10; j++) begin
            ok_cnt = 0;
            for (int s = 0; s < CLK_DIV; s++)
                if (samp[1 + j * CLK_DIV + s] === frame_bits[j]) ok_cnt++;
            check($sformatf("tx55_bit%0d_cycles", j), 16'(ok_cnt), 16'(CLK_DIV));
        end
        ok_cnt = 0;
        for (int k = 81; k < 90; k++) if (samp[k] === 1'b1) ok_cnt++;
        check("tx55_idle_after", 16'(ok_cnt), 16'd9);
        peek(A_STAT, d); check("tx55_status_empty", d, 16'h0004);
        wait_mon(1, 20, "tx55_mon_count");
        check("tx55_mon_byte", 16'(mon_q[0]), 16'h0055);
        mon_q.delete(); mon_t.delete();
        @(negedge clk);

        // ---- six back-to-back writes, sixth dropped ----
        for (int i = 1; i <= 5; i++) wr(A_DATA, 16'(i));
        peek(A_STAT, d); check("fifo_full_after_5", d & 16'h0006, 16'h0002);
        wr(A_DATA, 16'h0006);
        wait_mon(5, 5 * 80 + 60, "burst_mon_count");
        for (int i = 0; i < 5 && i < mon_q.size(); i++)
            check($sformatf("burst_byte%0d", i), 16'(mon_q[i]), 16'(i + 1));
        for (int i = 1; i < 5 && i < mon_t.size(); i++)
            check($sformatf("burst_gap%0d", i), 16'(mon_t[i] - mon_t[i-1]), 16'd80);
        idle(12);
        peek(A_STAT, d); check("burst_byte6_dropped", d, 16'h0004);
        check("burst_no_sixth_frame", 16'(mon_q.size()), 16'd5);
        mon_q.delete(); mon_t.delete();
        @(negedge clk);

        // ---- randomized TX bursts ----
        for (int b = 0; b < 4; b++) begin
            nb = $urandom_range(1, 4);
            exp_q.delete();
            for (int i = 0; i < nb; i++) begin
                rb = 8'($urandom);
                exp_q.push_back(rb);
                wr(A_DATA, {8'($urandom), rb});
            end
            wait_mon(nb, nb * 80 + 60, $sformatf("rtx%0d_count", b));
            for (int i = 0; i < nb && i < mon_q.size(); i++)
                check($sformatf("rtx%0d_byte%0d", b, i), 16'(mon_q[i]), 16'(exp_q[i]));
            idle(10);
            mon_q.delete(); mon_t.delete();
        end

        // ---- RX single frame 0xA3 ----
        send_rx(8'hA3, 1'b1);
        rd(A_STAT, d); check("rxA3_status", d, 16'h0005);
        rd(A_DATA, d); check("rxA3_data", d, 16'h00A3);
        rd(A_STAT, d); check("rxA3_status_cleared", d, 16'h0004);

        // ---- RX overrun ----
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        peek(A_DATA, d); check("ovr_data", d, 16'h0022);
        peek(A_STAT, d); check("ovr_status", d, 16'h000D);
        @(negedge clk);
        wr(A_STAT, 16'h0008);
        peek(A_STAT, d); check("ovr_cleared", d, 16'h0005);
        @(negedge clk);
        rd(A_DATA, d); check("ovr_read", d, 16'h0022);
        peek(A_STAT, d); check("ovr_status_final", d, 16'h0004);
        @(negedge clk);

        // ---- glitch and framing error ----
        uart_rxd = 1'b0;
        idle(2);
        uart_rxd = 1'b1;
        idle(20);
        peek(A_STAT, d); check("glitch_status", d, 16'h0004);
        @(negedge clk);
        send_rx(8'h5A, 1'b0);
        idle(10);
        peek(A_STAT, d); check("frame_err_status", d, 16'h0004);
        peek(A_DATA, d); check("frame_err_data_kept", d, 16'h0022);
        @(negedge clk);
        send_rx(8'hC6, 1'b1);
        peek(A_STAT, d); check("post_err_status", d, 16'h0005);
        @(negedge clk);
        rd(A_DATA, d); check("post_err_data", d, 16'h00C6);

        // ---- randomized RX against byte-level model ----
        m_valid = 1'b0; m_ovr = 1'b0; m_data = 8'hC6;
        for (int it = 0; it < 12; it++) begin
            rb = 8'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                send_rx(rb, 1'b0);
                idle(6);
            end else begin
                send_rx(rb, 1'b1);
                if (m_valid) m_ovr = 1'b1;
                m_valid = 1'b1;
                m_data  = rb;
            end
            case ($urandom_range(0, 3))
                0: begin
                    rd(A_DATA, d);
                    check($sformatf("rrx%0d_data", it), d, {8'h00, m_data});
                    m_valid = 1'b0;
                end
                1: begin
                    wr(A_STAT, 16'(8 | $urandom_range(0, 7)));
                    m_ovr = 1'b0;
                end
                default: idle(1);
            endcase
            peek(A_STAT, d);
            check($sformatf("rrx%0d_status", it), d, {12'h000, m_ovr, 1'b1, 1'b0, m_valid});
            @(negedge clk);
        end

        // ---- reset in the middle of a transmission ----
        mon_q.delete(); mon_t.delete();
        wr(A_DATA, 16'h0000);
        idle(30);
        check("midtx_line_low", 16'(uart_txd), 16'h0000);
        #2 rst_n = 1'b0;
        #1 check("midtx_async_txd", 16'(uart_txd), 16'h0001);
        peek(A_STAT, d); check("midtx_status_in_reset", d, 16'h0004);
        idle(3);
        rst_n = 1'b1;
        ok_cnt = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (uart_txd === 1'b1) ok_cnt++;
        end
        check("midtx_no_resume", 16'(ok_cnt), 16'd150);
        peek(A_STAT, d); check("midtx_status_after", d, 16'h0004);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
